collision_detector: RTL
=======================

COLLISION_DETECTOR -- requirements
Module: collision_detector

Interface
REQ-001 SHALL have parameter COOLDOWN_FRAMES, default 3, meaning frames during which a channel's repeat collision pulses are suppressed after it fires; legal range 0..15.
REQ-002 SHALL have port clk  input  1  system pixel clock; the only clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port startOfFrame  input  1  one-cycle frame-boundary strobe.
REQ-005 SHALL have port pause  input  1  game paused; level-sensitive.
REQ-006 SHALL have port draw_smiley  input  1  smiley pixel request for the current pixel.
REQ-007 SHALL have ports draw_border_top, draw_border_left, draw_border_right, draw_border_bottom  input  1 each  border pixel requests.
REQ-008 SHALL have port draw_flipper  input  1  flipper pixel request.
REQ-009 SHALL have ports collisionSmileyBorderTop, collisionSmileyBorderLeft, collisionSmileyBorderRight  output  1 each  one-cycle per-frame collision pulses.
REQ-010 SHALL have port collisionSmileyFlipper  output  1  one-cycle per-frame collision pulse.
REQ-011 SHALL have port ballLost  output  1  one-cycle pulse on a smiley/bottom-border collision.
REQ-012 SHALL have port collisionAny  output  1  OR of the five pulse outputs, same cycle.

Function
REQ-013 SHALL treat the five sources (top, left, right, flipper, bottom) as independent channels with identical behaviour.
REQ-014 SHALL set a channel's sticky hit flag on any clk where draw_smiley=1, the channel's draw input=1 and pause=0.
REQ-015 SHALL, on a clk with startOfFrame=1, evaluate every channel: if flag=1, cooldown=0 and pause=0, register its output pulse high and load cooldown with COOLDOWN_FRAMES; otherwise, if cooldown>0, decrement cooldown.
REQ-016 SHALL clear every flag on the startOfFrame clk, and SHALL credit an overlap occurring on that same clk to the new frame (its flag ends the cycle set).
REQ-017 SHALL drive each pulse output high for exactly one clk, the cycle after the startOfFrame clk; latency is 1 clk from strobe.
REQ-018 SHALL never assert any pulse output outside that one cycle.
REQ-019 SHALL, while pause=1, neither set flags nor emit pulses, SHALL still clear flags at startOfFrame, and SHALL hold cooldown values unchanged.
REQ-020 SHALL, with COOLDOWN_FRAMES=0, pulse on every frame whose previous frame contained an overlap.
REQ-021 SHALL fire multiple channels in the same cycle when multiple flags qualify, with no priority between them.
REQ-022 SHALL use a 4-bit unsigned cooldown counter per channel that saturates at 0 and never wraps.

Reset
REQ-023 SHALL, on a clk with reset=1, clear all flags, cooldowns and output registers to 0, overriding all other inputs.
REQ-024 SHALL drive all outputs 0 in the cycle after reset is sampled high, including when reset arrives mid-frame or coincides with startOfFrame.
REQ-025 SHALL discard any overlap seen before reset; the first pulse after reset requires an overlap in a post-reset frame.

Structure
REQ-026 SHALL take the channel index constants (TOP=0, LEFT=1, RIGHT=2, FLIPPER=3, BOTTOM=4), NUM_CHANNELS=5 and the cooldown width from the shared game package.
REQ-027 SHALL implement one channel (flag, cooldown, pulse register) as sub-module collision_channel, instantiated five times.
REQ-028 SHALL keep collisionAny and the bit-to-port mapping combinational at the top level, from registered channel outputs only.

Verification
REQ-029 SHALL cover: overlap of draw_smiley and draw_border_left for 4 clks in frame N -> collisionSmileyBorderLeft high exactly 1 clk, the cycle after frame N+1 startOfFrame; collisionAny identical.
REQ-030 SHALL cover: COOLDOWN_FRAMES=3, flipper overlap in every frame N..N+5 -> collisionSmileyFlipper pulses at boundaries N+1 and N+5 only.
REQ-031 SHALL cover: overlap only on the startOfFrame clk of frame N+1 -> no pulse at that boundary; pulse at boundary N+2.
REQ-032 SHALL cover: top and right overlaps in the same frame -> both outputs and collisionAny pulse in the same cycle.
REQ-033 SHALL cover: pause=1 throughout a frame with bottom overlaps -> ballLost stays 0; cooldown of 2 held across the paused frame.
REQ-034 SHALL cover: reset=1 on the startOfFrame clk following a frame with a left overlap -> no pulse; all outputs 0 next cycle.

Source files
------------

// File: rtl/collision_detector_pkg.sv
// ---------------------------------------------------------------------------
// collision_detector_pkg
// Shared game constants for the collision detector: channel indices, channel
// count, cooldown counter width and a small helper that decides whether the
// current pixel is an overlap worth recording.
// ---------------------------------------------------------------------------
package collision_detector_pkg;

  // Channel indices into the per-channel vectors used by the top level.
  localparam int TOP          = 0;
  localparam int LEFT         = 1;
  localparam int RIGHT        = 2;
  localparam int FLIPPER      = 3;
  localparam int BOTTOM       = 4;
  localparam int NUM_CHANNELS = 5;

  // Cooldown counters are 4 bits wide, covering 0..15 frames.
  localparam int COOLDOWN_W = 4;

  typedef logic [COOLDOWN_W-1:0]   cooldown_t;
  typedef logic [NUM_CHANNELS-1:0] channel_vec_t;

  // An overlap only counts while the game is running.
  function automatic logic overlapHit(input logic smiley, input logic draw,
                                      input logic pause);
    return smiley & draw & ~pause;
  endfunction

endpackage

// File: rtl/collision_channel.sv
// ---------------------------------------------------------------------------
// collision_channel
// One collision channel: a sticky hit flag that collects smiley/object
// overlaps during a frame, a cooldown counter that suppresses repeat pulses,
// and the registered one-cycle pulse issued after a frame boundary.
//
// Ports:
//   clk_i          pixel clock
//   reset_i        synchronous active-high reset
//   startOfFrame_i one-cycle frame-boundary strobe
//   pause_i        game paused (level)
//   smiley_i       smiley pixel request for the current pixel
//   draw_i         this channel's object pixel request
//   pulse_o        registered collision pulse, one cycle after the strobe
// ---------------------------------------------------------------------------
module collision_channel
  import collision_detector_pkg::*;
#(
  parameter int COOLDOWN_FRAMES = 3
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic startOfFrame_i,
  input  logic pause_i,
  input  logic smiley_i,
  input  logic draw_i,
  output logic pulse_o
);

  localparam cooldown_t COOLDOWN_LOAD = cooldown_t'(COOLDOWN_FRAMES);

  logic      flag_q, flag_d;
  cooldown_t cooldown_q, cooldown_d;
  logic      pulse_q, pulse_d;
  logic      hit;

  // Next-state logic. On a frame boundary the flag restarts from whatever
  // overlap is present on that very clock, so a boundary-cycle overlap is
  // credited to the new frame. The old flag value decides the pulse.
  // While paused the cooldown is frozen and no pulse can be issued.
  always_comb begin
    hit        = overlapHit(smiley_i, draw_i, pause_i);
    flag_d     = flag_q | hit;
    cooldown_d = cooldown_q;
    pulse_d    = 1'b0;
    if (startOfFrame_i) begin
      flag_d = hit;
      if (!pause_i) begin
        if (flag_q && (cooldown_q == '0)) begin
          pulse_d    = 1'b1;
          cooldown_d = COOLDOWN_LOAD;
        end else if (cooldown_q != '0) begin
          cooldown_d = cooldown_q - cooldown_t'(1);
        end
      end
    end
  end

  // State registers; reset wins over every other input.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      flag_q     <= 1'b0;
      cooldown_q <= '0;
      pulse_q    <= 1'b0;
    end else begin
      flag_q     <= flag_d;
      cooldown_q <= cooldown_d;
      pulse_q    <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/collision_detector.sv
// ---------------------------------------------------------------------------
// collision_detector
// Detects smiley collisions with the four borders and the flipper. Each
// source is an independent collision_channel; the top level only gathers the
// draw requests into a vector and maps the registered pulses to named ports.
//
// Ports:
//   clk, reset                    pixel clock, synchronous active-high reset
//   startOfFrame                  one-cycle frame-boundary strobe
//   pause                         game paused (level)
//   draw_smiley                   smiley pixel request
//   draw_border_top/left/right/bottom, draw_flipper   object pixel requests
//   collisionSmileyBorderTop/Left/Right, collisionSmileyFlipper
//                                 one-cycle per-frame collision pulses
//   ballLost                      smiley/bottom-border collision pulse
//   collisionAny                  OR of the five pulses
// ---------------------------------------------------------------------------
module collision_detector
  import collision_detector_pkg::*;
#(
  parameter int COOLDOWN_FRAMES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic startOfFrame,
  input  logic pause,
  input  logic draw_smiley,
  input  logic draw_border_top,
  input  logic draw_border_left,
  input  logic draw_border_right,
  input  logic draw_border_bottom,
  input  logic draw_flipper,
  output logic collisionSmileyBorderTop,
  output logic collisionSmileyBorderLeft,
  output logic collisionSmileyBorderRight,
  output logic collisionSmileyFlipper,
  output logic ballLost,
  output logic collisionAny
);

  channel_vec_t drawVec;
  channel_vec_t pulseVec;

  // Gather the object requests in channel-index order.
  always_comb begin
    drawVec          = '0;
    drawVec[TOP]     = draw_border_top;
    drawVec[LEFT]    = draw_border_left;
    drawVec[RIGHT]   = draw_border_right;
    drawVec[FLIPPER] = draw_flipper;
    drawVec[BOTTOM]  = draw_border_bottom;
  end

  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : gen_channel
    collision_channel #(
      .COOLDOWN_FRAMES (COOLDOWN_FRAMES)
    ) u_channel (
      .clk_i          (clk),
      .reset_i        (reset),
      .startOfFrame_i (startOfFrame),
      .pause_i        (pause),
      .smiley_i       (draw_smiley),
      .draw_i         (drawVec[ch]),
      .pulse_o        (pulseVec[ch])
    );
  end

  // Outputs come straight from the channel pulse registers, so collisionAny
  // is aligned with the individual pulses.
  assign collisionSmileyBorderTop   = pulseVec[TOP];
  assign collisionSmileyBorderLeft  = pulseVec[LEFT];
  assign collisionSmileyBorderRight = pulseVec[RIGHT];
  assign collisionSmileyFlipper     = pulseVec[FLIPPER];
  assign ballLost                   = pulseVec[BOTTOM];
  assign collisionAny               = |pulseVec;

endmodule
